petris_input_ctrl: RTL and testbench

Front-end stage for the tetrimino engine. Turns five raw push-buttons into the 3-bit `operation` code and provides the 10-bit `frame_number`, both held stable for a full frame so the engine can sample them on its `vsync` edge. Each button is synchronised and debounced, converted to press events with auto-repeat, and queued. Exactly one operation is issued per frame.

---
 rtl/petris_pkg.sv | 47 ++++
 rtl/button_debouncer.sv | 56 +++++
 rtl/petris_input_ctrl.sv | 125 ++++++++++++
 tb/tb_petris_input_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/petris_pkg.sv
// petris_pkg
//   Shared definitions for the tetrimino engine front end: operation codes,
//   issue priority, the per-operation pending vector type and board size.
//   Ports: none (package).
package petris_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_NONE   = 3'd0;
  localparam op_t OP_LEFT   = 3'd1;
  localparam op_t OP_RIGHT  = 3'd2;
  localparam op_t OP_ROTATE = 3'd3;
  localparam op_t OP_START  = 3'd4;
  localparam op_t OP_DROP   = 3'd5;

  localparam int NUM_OPS = 5;

  // One bit per operation, indexed directly by its op code.
  typedef logic [OP_DROP:OP_LEFT] pend_t;

  // Highest priority first.
  localparam op_t PRIO_ORDER [NUM_OPS] = '{OP_START, OP_DROP, OP_ROTATE, OP_LEFT, OP_RIGHT};

  // Buttons that auto-repeat while held: drop, right, left.
  localparam pend_t REPEATABLE = 5'b10011;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  function automatic op_t pick_op(input pend_t pend);
    op_t sel;
    sel = OP_NONE;
    // Walk from lowest to highest priority so the last hit wins.
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (pend[PRIO_ORDER[i]]) sel = PRIO_ORDER[i];
    end
    return sel;
  endfunction

  function automatic pend_t op_onehot(input op_t op);
    pend_t m;
    m = '0;
    if (op != OP_NONE) m[op] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
//   Two-flop synchroniser followed by a debounce counter for one raw button.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     raw        : asynchronous active-high button input
//     level      : debounced level
//     press      : one-cycle pulse on a debounced 0->1 transition
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // cnt holds the number of consecutive disagreeing cycles already seen;
  // the flip happens on the DEBOUNCE_CYCLES-th one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        level <= sync_q2;
        cnt   <= '0;
        press <= sync_q2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/petris_input_ctrl.sv
// petris_input_ctrl
//   Turns five raw buttons into one operation code per frame. Buttons are
//   debounced, converted to press events (with auto-repeat on left, right
//   and drop), queued in a pending register and issued in priority order on
//   each rising edge of the synchronised vsync.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     vsync               : frame strobe, asynchronous
//     btn_left .. btn_start : raw active-high buttons, asynchronous
//     operation           : op code for the current frame, held all frame
//     frame_number        : frame counter, wraps 1023 -> 0
module petris_input_ctrl
  import petris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_RATE     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_drop,
  input  logic       btn_start,
  output logic [2:0] operation,
  output logic [9:0] frame_number
);

  localparam int unsigned RCNT_W = $clog2(REPEAT_DELAY + 1);
  // The press frame is hold frame 1, so REPEAT_DELAY-1 frame edges remain
  // until the first repeat.
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RCNT_RATE = RCNT_W'(REPEAT_RATE);
  localparam logic [RCNT_W-1:0] RCNT_ONE  = RCNT_W'(1);

  pend_t raw;
  pend_t level;
  pend_t press;
  pend_t rep_ev;
  pend_t events;
  pend_t pending;
  pend_t pend_next;
  op_t   sel;

  logic vs_q1;
  logic vs_q2;
  logic vs_q3;
  logic frame_edge;

  assign raw = {btn_drop, btn_start, btn_rotate, btn_right, btn_left};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q1 <= 1'b0;
      vs_q2 <= 1'b0;
      vs_q3 <= 1'b0;
    end else begin
      vs_q1 <= vsync;
      vs_q2 <= vs_q1;
      vs_q3 <= vs_q2;
    end
  end

  assign frame_edge = vs_q2 & ~vs_q3;

  for (genvar g = 1; g <= NUM_OPS; g++) begin : g_btn
    logic [RCNT_W-1:0] rcnt;

    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[g]),
      .level(level[g]),
      .press(press[g])
    );

    // Down-counter of frame edges left until the next repeat. A fresh
    // press reloads it, so a press landing on a frame edge never repeats.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rcnt <= '0;
      end else if (!level[g]) begin
        rcnt <= '0;
      end else if (press[g]) begin
        rcnt <= RCNT_LOAD;
      end else if (frame_edge) begin
        rcnt <= (rcnt <= RCNT_ONE) ? RCNT_RATE : rcnt - RCNT_ONE;
      end
    end

    // Rotate and start are masked out here and never repeat.
    assign rep_ev[g] = REPEATABLE[g] & frame_edge & level[g] & ~press[g] & (rcnt <= RCNT_ONE);
  end

  // Selection looks only at the registered pending bits, so an event that
  // arrives on a frame edge waits for the next one. Set wins over clear.
  always_comb begin
    events    = press | rep_ev;
    sel       = OP_NONE;
    pend_next = pending | events;
    if (frame_edge) begin
      sel       = pick_op(pending);
      pend_next = (pending & ~op_onehot(sel)) | events;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      operation    <= OP_NONE;
      frame_number <= '0;
    end else begin
      pending <= pend_next;
      if (frame_edge) begin
        operation    <= sel;
        frame_number <= frame_number + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_petris_input_ctrl.sv
module tb_petris_input_ctrl;

  localparam int DEB   = 4;
  localparam int DLY   = 3;
  localparam int RATE  = 2;
  localparam int FRAME = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       vsync = 1'b0;
  logic [5:1] btn = '0;   // 1 left, 2 right, 3 rotate, 4 start, 5 drop
  logic [2:0] operation;
  logic [9:0] frame_number;

  petris_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_RATE    (RATE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .btn_left    (btn[1]),
    .btn_right   (btn[2]),
    .btn_rotate  (btn[3]),
    .btn_drop    (btn[5]),
    .btn_start   (btn[4]),
    .operation   (operation),
    .frame_number(frame_number)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int prev_frame = -1;
  int op_log[$];

  // Behavioural reference: raw history, run lengths, hold-frame counts.
  bit [5:1] m_d1, m_d2, m_lvl, m_pulse, m_pend;
  bit [2:0] m_vh;
  int       m_run [1:5];
  int       m_hold[1:5];
  int       m_op, m_frame;
  int       prio[5] = '{4, 5, 3, 1, 2};

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pulse = '0; m_pend = '0; m_vh = '0;
    m_op = 0; m_frame = 0;
    for (int b = 1; b <= 5; b++) begin
      m_run[b]  = 0;
      m_hold[b] = 0;
    end
  endtask

  task automatic model_edge();
    bit       fe;
    bit [5:1] ev;
    bit [5:1] np;
    int       sel;
    fe = m_vh[1] && !m_vh[2];
    ev = m_pulse;
    for (int b = 1; b <= 5; b++) begin
      if (!m_lvl[b]) m_hold[b] = 0;
      else if (m_pulse[b]) m_hold[b] = 1;
      else if (fe) begin
        m_hold[b]++;
        if ((b == 1 || b == 2 || b == 5) && m_hold[b] >= DLY && ((m_hold[b] - DLY) % RATE) == 0)
          ev[b] = 1'b1;
      end
    end
    if (fe) begin
      m_frame = (m_frame + 1) % 1024;
      sel = 0;
      for (int i = 0; i < 5; i++)
        if (sel == 0 && m_pend[prio[i]]) sel = prio[i];
      m_op = sel;
      if (sel != 0) m_pend[sel] = 1'b0;
    end
    m_pend |= ev;
    np = '0;
    for (int b = 1; b <= 5; b++) begin
      if (m_d2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_lvl[b] = m_d2[b];
          m_run[b] = 0;
          np[b]    = m_d2[b];
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_pulse = np;
    m_d2    = m_d1;
    m_d1    = btn;
    m_vh    = {m_vh[1:0], vsync};
  endtask

  task automatic check_frame();
    check_val("operation", int'(operation), m_op);
    check_val("frame_number", int'(frame_number), m_frame);
    check_val("op_legal", int'(operation < 3'd6), 1);
    if (prev_frame == 1023) check_val("frame_wrap", int'(frame_number), 0);
    prev_frame = int'(frame_number);
    op_log.push_back(int'(operation));
  endtask

  task automatic step();
    vsync = ((cyc % FRAME) < 5);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    if ((cyc % FRAME) == 27) check_frame();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < FRAME && (cyc % FRAME) != p; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_operation", int'(operation), 0);
    check_val("rst_frame_number", int'(frame_number), 0);
    run(3);
    rst_n = 1'b1;
  endtask

  int exp_left[13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
  int cnt_rot;
  int b_sel;

  initial begin
    model_reset();
    #1;
    do_reset();
    run(2 * FRAME);

    // rotate bounces then holds: exactly one issue, no repeat
    wait_phase(10);
    btn[3] = 1'b1; run(2);
    btn[3] = 1'b0; run(2);
    btn[3] = 1'b1;
    op_log.delete();
    run(500);
    btn[3] = 1'b0;
    run(100);
    cnt_rot = 0;
    foreach (op_log[i]) if (op_log[i] == 3) cnt_rot++;
    check_val("rotate_once", cnt_rot, 1);

    // left held ~10 frames: issued on odd frames after the press
    wait_phase(10);
    op_log.delete();
    btn[1] = 1'b1;
    run(470);
    btn[1] = 1'b0;
    run(150);
    if (op_log.size() < 13) check_val("left_log_len", op_log.size(), 13);
    else for (int i = 0; i < 13; i++) check_val($sformatf("left_f%0d", i), op_log[i], exp_left[i]);

    // start and drop in the same frame
    wait_phase(10);
    op_log.delete();
    btn[4] = 1'b1; btn[5] = 1'b1;
    run(20);
    btn[4] = 1'b0; btn[5] = 1'b0;
    run(180);
    if (op_log.size() < 4) check_val("sd_log_len", op_log.size(), 4);
    else begin
      check_val("sd_start", op_log[1], 4);
      check_val("sd_drop", op_log[2], 5);
      check_val("sd_none", op_log[3], 0);
    end

    // right press event lands on the frame-edge cycle
    wait_phase(46);
    op_log.delete();
    btn[2] = 1'b1;
    run(20);
    btn[2] = 1'b0;
    run(120);
    if (op_log.size() < 2) check_val("edge_log_len", op_log.size(), 2);
    else begin
      check_val("edge_same_frame", op_log[0], 0);
      check_val("edge_next_frame", op_log[1], 2);
    end

    // reset mid-frame with left pending: nothing issued afterwards
    wait_phase(10);
    btn[1] = 1'b1; run(10);
    btn[1] = 1'b0; run(10);
    do_reset();
    op_log.delete();
    run(100);
    if (op_log.size() < 1) check_val("rst_log_len", op_log.size(), 1);
    else check_val("rst_no_issue", op_log[0], 0);

    // button held across reset is taken as a fresh press
    wait_phase(10);
    btn[2] = 1'b1; run(20);
    do_reset();
    op_log.delete();
    run(150);
    btn[2] = 1'b0;
    run(50);
    if (op_log.size() < 1) check_val("fresh_log_len", op_log.size(), 1);
    else check_val("rst_fresh_press", op_log[0], 2);

    // random button activity over enough frames to wrap frame_number
    for (int i = 0; i < 1030 * FRAME; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        b_sel = $urandom_range(1, 5);
        btn[b_sel] = ~btn[b_sel];
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
